// File: rtl/free_list_ctrl_if.sv
// Allocation / free / status bundle between free_list_ctrl and the ingress write controllers.
interface free_list_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] fl_alloc_req_i;
  logic [NUM_REQ-1:0] fl_alloc_gnt_o;
  logic [ADDR_W-1:0]  fl_alloc_block_idx_o;
  logic               fl_free_valid_i;
  logic [ADDR_W-1:0]  fl_free_idx_i;
  logic [ADDR_W:0]    fl_count_o;
  logic               fl_empty_o;
  logic               init_done_o;
  logic               err_overflow_o;

  modport master (
    output fl_alloc_req_i, fl_free_valid_i, fl_free_idx_i,
    input  fl_alloc_gnt_o, fl_alloc_block_idx_o, fl_count_o, fl_empty_o,
           init_done_o, err_overflow_o
  );

  modport slave (
    input  fl_alloc_req_i, fl_free_valid_i, fl_free_idx_i,
    output fl_alloc_gnt_o, fl_alloc_block_idx_o, fl_count_o, fl_empty_o,
           init_done_o, err_overflow_o
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Free block-index pool: self-seeds after reset, round-robin allocates to NUM_REQ
// requesters, and takes back freed indices into a circular FIFO.
module free_list_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int NUM_BLOCKS = 256,
  parameter int NUM_REQ    = 2
) (
  input  logic             clk,
  input  logic             rst,
  free_list_ctrl_if.slave  fl
);
  localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   mem [NUM_BLOCKS];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [REQ_W-1:0]    last_gnt, pick, cidx;
  logic                pick_vld;
  logic [NUM_REQ-1:0]  gnt_q, gnt_nxt, elig;
  logic [ADDR_W-1:0]   idx_q;
  logic                init_done_q, err_q;
  logic                full, empty, init_wr, do_gnt, do_free, drop;

  // A requester granted last cycle cannot yet have dropped its level request.
  assign elig  = fl.fl_alloc_req_i & ~gnt_q;
  assign full  = (count == CNT_W'(NUM_BLOCKS));
  assign empty = (count == '0);

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cidx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cidx = REQ_W'((int'(last_gnt) + k) % NUM_REQ);
      if (!pick_vld && elig[cidx]) begin
        pick_vld = 1'b1;
        pick     = cidx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    init_wr   = (state == S_INIT);
    do_gnt    = (state == S_READY) && pick_vld && !empty;
    do_free   = (state == S_READY) && fl.fl_free_valid_i && !full;
    drop      = fl.fl_free_valid_i && ((state == S_INIT) || full);
    gnt_nxt   = '0;
    if (do_gnt) gnt_nxt[pick] = 1'b1;
    if (state == S_INIT && wr_ptr == PTR_W'(NUM_BLOCKS - 1)) state_nxt = S_READY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      last_gnt    <= REQ_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt_q       <= gnt_nxt;
      init_done_q <= (state_nxt == S_READY);
      if (do_gnt) begin
        idx_q    <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        last_gnt <= pick;
      end
      if (init_wr || do_free) wr_ptr <= wr_ptr + 1'b1;
      // Grant and free in the same cycle cancel out on the count.
      if ((init_wr || do_free) && !do_gnt)      count <= count + 1'b1;
      else if (do_gnt && !(init_wr || do_free)) count <= count - 1'b1;
      if (drop) err_q <= 1'b1;
    end
  end

  // Storage is not reset; the seeding pass rewrites every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_wr)      mem[wr_ptr] <= ADDR_W'(wr_ptr);
      else if (do_free) mem[wr_ptr] <= fl.fl_free_idx_i;
    end
  end

  assign fl.fl_alloc_gnt_o       = gnt_q;
  assign fl.fl_alloc_block_idx_o = idx_q;
  assign fl.fl_count_o           = count;
  assign fl.fl_empty_o           = empty;
  assign fl.init_done_o          = init_done_q;
  assign fl.err_overflow_o       = err_q;
endmodule

// File: tb/tb_free_list_ctrl.sv
// Bench for free_list_ctrl: a 256-block and a 4-block instance checked against a queue model
// with a grant scoreboard plus directed expectations.
module tb_free_list_ctrl;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, sel;
  logic [1:0]    req;
  logic          fv;
  logic [AW-1:0] fidx;

  free_list_ctrl_if #(.ADDR_W(AW), .NUM_REQ(2)) ifa ();
  free_list_ctrl_if #(.ADDR_W(AW), .NUM_REQ(2)) ifb ();

  assign ifa.fl_alloc_req_i  = req;
  assign ifa.fl_free_valid_i = fv;
  assign ifa.fl_free_idx_i   = fidx;
  assign ifb.fl_alloc_req_i  = req;
  assign ifb.fl_free_valid_i = fv;
  assign ifb.fl_free_idx_i   = fidx;

  free_list_ctrl #(.ADDR_W(AW), .NUM_BLOCKS(256), .NUM_REQ(2)) dut_a (.clk(clk), .rst(rst_a), .fl(ifa));
  free_list_ctrl #(.ADDR_W(AW), .NUM_BLOCKS(4),   .NUM_REQ(2)) dut_b (.clk(clk), .rst(rst_b), .fl(ifb));

  logic [1:0]    o_gnt;
  logic [AW-1:0] o_idx;
  logic [AW:0]   o_cnt;
  logic          o_empty, o_init, o_err;

  always_comb begin
    o_gnt   = sel ? ifb.fl_alloc_gnt_o       : ifa.fl_alloc_gnt_o;
    o_idx   = sel ? ifb.fl_alloc_block_idx_o : ifa.fl_alloc_block_idx_o;
    o_cnt   = sel ? ifb.fl_count_o           : ifa.fl_count_o;
    o_empty = sel ? ifb.fl_empty_o           : ifa.fl_empty_o;
    o_init  = sel ? ifb.init_done_o          : ifa.init_done_o;
    o_err   = sel ? ifb.err_overflow_o       : ifa.err_overflow_o;
  end

  typedef struct { logic [1:0] gnt; logic [AW-1:0] idx; } exp_t;

  int            n_chk = 0, n_err = 0;
  int            m_n;
  int            m_q[$];
  logic          m_last;
  logic [1:0]    m_prev;
  int            m_init;
  logic          m_ready, m_err;
  logic [AW-1:0] m_idx;
  exp_t          sb[$];
  int            glog_req[$], glog_idx[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Predict the next edge from the inputs being driven now; grants go to the scoreboard.
  task automatic model_eval();
    logic       cur_rst, full, pv, c0;
    logic [1:0] g;
    cur_rst = sel ? rst_b : rst_a;
    if (cur_rst) begin
      m_q.delete(); sb.delete();
      m_last = 1'b1; m_prev = '0; m_init = 0; m_ready = 1'b0; m_err = 1'b0; m_idx = '0;
    end else if (!m_ready) begin
      m_q.push_back(m_init);
      m_init++;
      if (m_init == m_n) m_ready = 1'b1;
      if (fv) m_err = 1'b1;
      m_prev = '0;
    end else begin
      full = (m_q.size() == m_n);
      g    = '0;
      pv   = 1'b0;
      c0   = ~m_last;
      if (req[c0] && !m_prev[c0]) pv = 1'b1;
      else if (req[m_last] && !m_prev[m_last]) begin pv = 1'b1; c0 = m_last; end
      if (pv && m_q.size() > 0) begin
        g[c0]  = 1'b1;
        m_idx  = AW'(m_q.pop_front());
        m_last = c0;
        sb.push_back('{gnt: g, idx: m_idx});
      end
      if (fv) begin
        if (!full) m_q.push_back(int'(fidx));
        else       m_err = 1'b1;
      end
      m_prev = g;
    end
  endtask

  task automatic mon();
    exp_t e;
    if (o_gnt != 2'b00) begin
      glog_req.push_back(o_gnt[1] ? 1 : 0);
      glog_idx.push_back(int'(o_idx));
      if (sb.size() == 0) chk("spurious_gnt", 32'(o_gnt), 32'd0);
      else begin
        e = sb.pop_front();
        chk("gnt", 32'(o_gnt), 32'(e.gnt));
        chk("gnt_idx", 32'(o_idx), 32'(e.idx));
      end
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("missing_gnt", 32'(o_gnt), 32'(e.gnt));
    end
    chk("idx_hold", 32'(o_idx), 32'(m_idx));
    chk("count", 32'(o_cnt), 32'(m_q.size()));
    chk("empty", 32'(o_empty), 32'(m_q.size() == 0));
    chk("init_done", 32'(o_init), 32'(m_ready));
    chk("err", 32'(o_err), 32'(m_err));
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_gnt"},   32'(o_gnt),   32'd0);
    chk({tag, "_idx"},   32'(o_idx),   32'd0);
    chk({tag, "_cnt"},   32'(o_cnt),   32'd0);
    chk({tag, "_empty"}, 32'(o_empty), 32'd1);
    chk({tag, "_init"},  32'(o_init),  32'd0);
    chk({tag, "_err"},   32'(o_err),   32'd0);
  endtask

  // Bounded wait for init_done after reset release.
  task automatic run_init(input int n);
    int cyc;
    cyc = 0;
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    while (!o_init && cyc < n + 20) begin step(); cyc++; end
    chk("init_cycles", 32'(cyc), 32'(n));
    chk("init_count", 32'(o_cnt), 32'(n));
    chk("init_empty", 32'(o_empty), 32'd0);
  endtask

  task automatic clr_log();
    glog_req.delete();
    glog_idx.delete();
  endtask

  initial begin
    int g;
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; req = '0; fv = 1'b0; fidx = '0; m_n = 256;
    step(); step();
    reset_check("rst");

    // Seeding with both requesters asserted: the model flags any grant.
    req = 2'b11;
    run_init(256);
    req = 2'b00;
    step();

    clr_log();
    req = 2'b01;
    repeat (8) step();
    req = 2'b00;
    step();
    chk("single_n", 32'(glog_req.size()), 32'd4);
    for (int i = 0; i < glog_req.size() && i < 4; i++) begin
      chk("single_req", 32'(glog_req[i]), 32'd0);
      chk("single_idx", 32'(glog_idx[i]), 32'(i));
    end
    chk("single_cnt", 32'(o_cnt), 32'd252);

    rst_a = 1'b1; step();
    run_init(256);
    clr_log();
    req = 2'b11;
    repeat (4) step();
    chk("rr_n", 32'(glog_req.size()), 32'd4);
    for (int i = 0; i < glog_req.size() && i < 4; i++) begin
      chk("rr_req", 32'(glog_req[i]), 32'(i % 2));
      chk("rr_idx", 32'(glog_idx[i]), 32'(i));
    end

    g = 0;
    while (m_q.size() > 10 && g < 400) begin step(); g++; end
    chk("drain_cnt", 32'(o_cnt), 32'd10);
    fv = 1'b1; fidx = 8'd7;
    step();
    fv = 1'b0;
    chk("simul_cnt", 32'(o_cnt), 32'd10);
    clr_log();
    g = 0;
    while (glog_idx.size() < 10 && g < 40) begin step(); g++; end
    chk("simul_n", 32'(glog_idx.size()), 32'd10);
    if (glog_idx.size() >= 10) begin
      chk("simul_first", 32'(glog_idx[0]), 32'd247);
      chk("simul_prev", 32'(glog_idx[8]), 32'd255);
      chk("simul_freed", 32'(glog_idx[9]), 32'd7);
    end

    req = 2'b00;
    rst_a = 1'b1; step();
    run_init(256);
    fv = 1'b1; fidx = 8'd5;
    step();
    fv = 1'b0;
    chk("ovf_err", 32'(o_err), 32'd1);
    chk("ovf_cnt", 32'(o_cnt), 32'd256);
    req = 2'b11;
    repeat (5) step();
    rst_a = 1'b1;
    step();
    reset_check("midrst");
    req = 2'b00;
    run_init(256);
    chk("midrst_err", 32'(o_err), 32'd0);

    rst_a = 1'b1; sel = 1'b1; m_n = 4;
    step();
    reset_check("b_rst");
    run_init(4);
    clr_log();
    req = 2'b11;
    repeat (6) step();
    chk("ex_n", 32'(glog_idx.size()), 32'd4);
    for (int i = 0; i < glog_idx.size() && i < 4; i++)
      chk("ex_idx", 32'(glog_idx[i]), 32'(i));
    chk("ex_empty", 32'(o_empty), 32'd1);
    chk("ex_cnt", 32'(o_cnt), 32'd0);

    req = 2'b00; fv = 1'b1; fidx = 8'd2;
    step();
    fv = 1'b0;
    chk("ex_free_cnt", 32'(o_cnt), 32'd1);
    clr_log();
    req = 2'b11;
    step();
    chk("ex_regnt_n", 32'(glog_idx.size()), 32'd1);
    if (glog_idx.size() >= 1) chk("ex_regnt_idx", 32'(glog_idx[0]), 32'd2);
    chk("ex_regnt_empty", 32'(o_empty), 32'd1);

    fv = 1'b1; fidx = 8'd1;
    step();
    fv = 1'b0;
    chk("ex_simul_n", 32'(glog_idx.size()), 32'd1);
    chk("ex_simul_cnt", 32'(o_cnt), 32'd1);
    step();
    chk("ex_late_n", 32'(glog_idx.size()), 32'd2);
    if (glog_idx.size() >= 2) chk("ex_late_idx", 32'(glog_idx[1]), 32'd1);
    req = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
